// File: rtl/amber48_pkg.sv
// amber48_pkg -- shared types and constants for the amber48 data-memory path.
//   XLEN                      : datapath width (address and data).
//   DMEM_ARB_TIMEOUT_DEFAULT  : default BUSY-cycle budget of the dmem arbiter.
//   dmem_arb_state_e          : arbiter FSM states.
package amber48_pkg;

    localparam int XLEN                     = 48;
    localparam int DMEM_ARB_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_arb_state_e;

endpackage

// File: rtl/amber48_rr_arb2.sv
// amber48_rr_arb2 -- two-way round-robin pick.
//   req[1:0]   in  : request lines of requester 0 and 1.
//   last_grant in  : index of the requester served most recently.
//   valid      out : at least one request is present.
//   idx        out : index of the winner (meaningful only when valid).
module amber48_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       idx
);

    always_comb begin
        valid = |req;
        // On a tie the requester that was not served last wins; otherwise
        // the lone requester wins (req[1] selects index 1).
        idx   = (&req) ? ~last_grant : req[1];
    end

endmodule

// File: rtl/amber48_dmem_arbiter.sv
// amber48_dmem_arbiter -- arbitrates the core (m0) and the loader/debug port
// (m1) onto a single data-memory port, one transaction at a time.
//   clk_i, rst_i                     : clock, synchronous active-high reset.
//   m0_* / m1_*                      : requester ports (req/we/addr/wdata in,
//                                      rdata/ready/trap out).
//   dmem_req/we/addr/wdata_o         : downstream request, valid only in BUSY.
//   dmem_rdata/ready/trap_i          : downstream response.
//   busy_o                           : a transaction is in flight.
//   grant_o                          : current or most recent owner.
// A BUSY phase lasting TIMEOUT_CYCLES cycles without dmem_ready_i ends with a
// trap response and zero read data.
module amber48_dmem_arbiter
    import amber48_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DMEM_ARB_TIMEOUT_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            m0_req_i,
    input  logic            m0_we_i,
    input  logic [XLEN-1:0] m0_addr_i,
    input  logic [XLEN-1:0] m0_wdata_i,
    output logic [XLEN-1:0] m0_rdata_o,
    output logic            m0_ready_o,
    output logic            m0_trap_o,
    input  logic            m1_req_i,
    input  logic            m1_we_i,
    input  logic [XLEN-1:0] m1_addr_i,
    input  logic [XLEN-1:0] m1_wdata_i,
    output logic [XLEN-1:0] m1_rdata_o,
    output logic            m1_ready_o,
    output logic            m1_trap_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic [XLEN-1:0] dmem_rdata_i,
    input  logic            dmem_ready_i,
    input  logic            dmem_trap_i,
    output logic            busy_o,
    output logic            grant_o
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dmem_arb_state_e state, next_state;

    logic [CNT_W-1:0] cnt;
    logic             grant_q;
    logic             last_grant_q;
    logic             we_q;
    logic [XLEN-1:0]  addr_q;
    logic [XLEN-1:0]  wdata_q;
    logic             trap_q;
    logic [XLEN-1:0]  m0_rdata_q;
    logic [XLEN-1:0]  m1_rdata_q;

    logic arb_valid;
    logic arb_idx;
    logic in_busy;
    logic in_resp;
    logic timed_out;

    amber48_rr_arb2 u_rr (
        .req        ({m1_req_i, m0_req_i}),
        .last_grant (last_grant_q),
        .valid      (arb_valid),
        .idx        (arb_idx)
    );

    assign in_busy   = (state == BUSY);
    assign in_resp   = (state == RESP);
    assign timed_out = (cnt == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: next_state gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        next_state = state;
        unique case (state)
            IDLE:    if (arb_valid) next_state = BUSY;
            // Ready and timeout both exit to RESP; the datapath decides
            // which one wins.
            BUSY:    if (dmem_ready_i || timed_out) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: registered state is written with non-blocking assignments only,
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt          <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;  // m0 wins the first tie after reset
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            trap_q       <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant_q <= arb_idx;
                        we_q    <= arb_idx ? m1_we_i    : m0_we_i;
                        addr_q  <= arb_idx ? m1_addr_i  : m0_addr_i;
                        wdata_q <= arb_idx ? m1_wdata_i : m0_wdata_i;
                        cnt     <= '0;
                    end
                end
                BUSY: begin
                    if (dmem_ready_i) begin
                        // Ready takes priority over a coinciding timeout.
                        trap_q <= dmem_trap_i;
                        if (grant_q) m1_rdata_q <= we_q ? '0 : dmem_rdata_i;
                        else         m0_rdata_q <= we_q ? '0 : dmem_rdata_i;
                    end else if (timed_out) begin
                        trap_q <= 1'b1;
                        if (grant_q) m1_rdata_q <= '0;
                        else         m0_rdata_q <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP:    last_grant_q <= grant_q;
                default: ;
            endcase
        end
    end

    assign busy_o       = (state != IDLE);
    assign grant_o      = grant_q;

    assign dmem_req_o   = in_busy;
    assign dmem_we_o    = in_busy & we_q;
    assign dmem_addr_o  = in_busy ? addr_q  : '0;
    assign dmem_wdata_o = in_busy ? wdata_q : '0;

    assign m0_rdata_o   = m0_rdata_q;
    assign m1_rdata_o   = m1_rdata_q;
    assign m0_ready_o   = in_resp & ~grant_q;
    assign m1_ready_o   = in_resp &  grant_q;
    assign m0_trap_o    = in_resp & ~grant_q & trap_q;
    assign m1_trap_o    = in_resp &  grant_q & trap_q;

endmodule

// File: doc/amber48_dmem_arbiter.md
AMBER48_DMEM_ARBITER -- requirements
Module: amber48_dmem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the number of BUSY cycles without dmem_ready_i before the arbiter aborts with a trap (legal range 2..1023).
REQ-002 SHALL have ports: clk_i  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: rst_i  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: m0_req_i, m0_we_i  in  1 each  core request and write-enable.
REQ-005 SHALL have ports: m0_addr_i, m0_wdata_i  in  XLEN each  core address and write data.
REQ-006 SHALL have ports: m0_rdata_o  out  XLEN, and m0_ready_o, m0_trap_o  out  1 each  core response.
REQ-007 SHALL have ports: m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_rdata_o, m1_ready_o, m1_trap_o, with the same widths and meaning as m0, for the auxiliary (loader/debug) requester.
REQ-008 SHALL have ports: dmem_req_o, dmem_we_o  out  1; dmem_addr_o, dmem_wdata_o  out  XLEN  downstream request.
REQ-009 SHALL have ports: dmem_rdata_i  in  XLEN; dmem_ready_i, dmem_trap_i  in  1  downstream response.
REQ-010 SHALL have ports: busy_o  out  1  (state != IDLE); grant_o  out  1  (index of the current or most recent owner).

Function
REQ-011 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-012 In IDLE with any mN_req_i high, SHALL latch the winner's we/addr/wdata, set grant_o, and enter BUSY.
REQ-013 Arbitration SHALL be round-robin: when both request, the requester not equal to last_grant wins; a lone requester always wins.
REQ-014 In BUSY, dmem_req_o SHALL be 1 and dmem_we/addr/wdata_o SHALL equal the latched values, stable until exit; latency from mN_req_i high in IDLE to dmem_req_o is exactly 1 cycle.
REQ-015 In BUSY with dmem_ready_i=1, SHALL register dmem_rdata_i (0 on writes), register dmem_trap_i, and enter RESP.
REQ-016 In RESP, SHALL drive the granted mN_ready_o=1 for exactly one cycle, with mN_rdata_o and mN_trap_o valid; dmem_req_o=0; the other requester's ready/trap SHALL stay 0.
REQ-017 The timeout counter SHALL clear on BUSY entry and increment each BUSY cycle; reaching TIMEOUT_CYCLES-1 without ready SHALL enter RESP with trap=1 and rdata=0.
REQ-018 If dmem_ready_i and timeout coincide, dmem_ready_i SHALL win (normal completion).
REQ-019 Requests SHALL be ignored in BUSY and RESP; requesters hold req/addr/wdata until their ready; a request dropped mid-transaction still completes and its ready pulse is still issued.
REQ-020 last_grant SHALL update on RESP -> IDLE; minimum spacing between transactions is 3 cycles (IDLE, BUSY>=1, RESP).
REQ-021 mN_rdata_o SHALL hold its last value between responses; dmem_*_o SHALL be 0 outside BUSY.

Reset
REQ-022 While rst_i=1, SHALL force: state=IDLE; all outputs=0; counter=0; last_grant=1, so m0 wins the first tie.
REQ-023 Reset asserted mid-BUSY or mid-RESP SHALL abort without issuing any ready pulse; the next cycle after release is IDLE.

Structure
REQ-024 XLEN, typedef dmem_arb_state_e {IDLE, BUSY, RESP}, and DMEM_ARB_TIMEOUT_DEFAULT=64 SHALL live in amber48_pkg.
REQ-025 A sub-module amber48_rr_arb2 (2-way round-robin pick from req[1:0] and last_grant) is natural; everything else stays flat.
REQ-026 Counter width SHALL be $clog2(TIMEOUT_CYCLES), with no wrap in BUSY.

Verification
REQ-027 Core read: m0 read addr 0x10, downstream returns ready with rdata 0x123456789ABC after 2 cycles -> dmem_req_o high cycles 1-3, m0_ready_o pulse cycle 4 with rdata 0x123456789ABC, m1 outputs 0.
REQ-028 Contention: m0 and m1 both request from reset -> m0 served first, then m1, grant_o 0 then 1; repeated contention alternates 0,1,0,1.
REQ-029 Timeout with TIMEOUT_CYCLES=8: downstream never ready -> m1_trap_o=1 and m1_ready_o=1 after 8 BUSY cycles, rdata 0, dmem_req_o drops.
REQ-030 Boundary: dmem_ready_i in the last timeout cycle -> normal response, trap=0; dmem_trap_i=1 on a write to an unmapped addr -> m0_trap_o=1 with ready.
REQ-031 Reset mid-BUSY: rst_i pulsed during a pending m1 write -> no ready pulse, busy_o=0, next m0/m1 tie grants m0.
